// File: rtl/rr_index_arbiter.sv
// rtl/rr_index_arbiter.sv - round-robin 8-way arbiter with registered grant index, ack release and hold timeout
module rr_index_arbiter #(
    parameter int N       = 8,
    parameter int IDX_W   = 3,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [N-1:0]     req,
    input  logic             ack,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid,
    output logic             timeout
);

    // Hold counter needs at least one bit even when the timeout is disabled.
    localparam int HCNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [HCNT_W-1:0] HCNT_LAST = (TIMEOUT > 0) ? HCNT_W'(TIMEOUT - 1) : '0;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t              state_q;
    logic [IDX_W-1:0]    ptr_q;
    logic [HCNT_W-1:0]   hcnt_q;
    logic [IDX_W-1:0]    grant_idx_q;
    logic                grant_valid_q;
    logic                timeout_q;

    logic [IDX_W-1:0]    search_idx_d;
    logic [IDX_W-1:0]    cand;
    logic                found;

    // First requester at or after the pointer, wrapping modulo N.
    always_comb begin
        search_idx_d = ptr_q;
        found        = 1'b0;
        cand         = '0;
        for (int k = 0; k < N; k++) begin
            cand = ptr_q + IDX_W'(k);
            if (!found && req[cand]) begin
                search_idx_d = cand;
                found        = 1'b1;
            end
        end
    end

    // Grant FSM: all outputs and bookkeeping registered in one place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            hcnt_q        <= '0;
            grant_idx_q   <= '0;
            grant_valid_q <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (enable && (req != '0)) begin
                        grant_idx_q   <= search_idx_d;
                        grant_valid_q <= 1'b1;
                        hcnt_q        <= '0;
                        state_q       <= GRANT;
                    end
                end
                GRANT: begin
                    if (!enable) begin
                        // Forced drop leaves the pointer alone so the same requester can win again.
                        grant_valid_q <= 1'b0;
                        state_q       <= IDLE;
                    end else if (ack) begin
                        grant_valid_q <= 1'b0;
                        ptr_q         <= grant_idx_q + IDX_W'(1);
                        state_q       <= IDLE;
                    end else if ((TIMEOUT != 0) && (hcnt_q == HCNT_LAST)) begin
                        grant_valid_q <= 1'b0;
                        timeout_q     <= 1'b1;
                        ptr_q         <= grant_idx_q + IDX_W'(1);
                        state_q       <= IDLE;
                    end else begin
                        hcnt_q <= hcnt_q + HCNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign grant_idx   = grant_idx_q;
    assign grant_valid = grant_valid_q;
    assign timeout     = timeout_q;

endmodule
